custom_ip_regfile: RTL and testbench

CUSTOM_IP_REGFILE -- requirements
Module: custom_ip_regfile

---
 rtl/custom_ip_regfile.sv | 115 +++++++++++
 tb/tb_custom_ip_regfile.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_ip_regfile.sv
// APB register file: per-channel CTRL push registers with valid/ack handshake,
// STAT capture registers with new/overflow flags, and a level interrupt.
module custom_ip_regfile #(
  parameter int unsigned NUM_CH = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [11:0]             paddr_i,
  input  logic [31:0]             pwdata_i,
  output logic [31:0]             prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic [NUM_CH-1:0][31:0] reg2ip_data_o,
  output logic [NUM_CH-1:0]       reg2ip_valid_o,
  input  logic [NUM_CH-1:0]       reg2ip_ack_i,
  input  logic [NUM_CH-1:0][31:0] ip2reg_data_i,
  input  logic [NUM_CH-1:0]       ip2reg_valid_i,
  output logic                    irq_o
);

  localparam logic [9:0] StatusWord = 10'(2 * NUM_CH);
  localparam logic [9:0] IrqEnWord  = 10'(2 * NUM_CH + 1);

  logic [NUM_CH-1:0][31:0] ctrl;
  logic [NUM_CH-1:0][31:0] stat;
  logic [NUM_CH-1:0]       pend;
  logic [NUM_CH-1:0]       new_flag;
  logic [NUM_CH-1:0]       ovf_flag;
  logic [NUM_CH-1:0]       irq_en;

  logic [9:0]        word;
  logic              access;
  logic              mapped;
  logic              err;
  logic              stall;
  logic              done;
  logic              wr;
  logic              rd;
  logic              status_hit;
  logic              irq_en_hit;
  logic [NUM_CH-1:0] ctrl_hit;
  logic [NUM_CH-1:0] stat_hit;
  logic [NUM_CH-1:0] clr_new;
  logic [NUM_CH-1:0] clr_ovf;
  logic [31:0]       rdata;

  always_comb begin
    word     = paddr_i[11:2];
    access   = psel_i & penable_i;
    ctrl_hit = '0;
    stat_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ctrl_hit[i] = (word == 10'(i));
      stat_hit[i] = (word == 10'(NUM_CH + i));
    end
    status_hit = (word == StatusWord);
    irq_en_hit = (word == IrqEnWord);
    mapped     = (|ctrl_hit) | (|stat_hit) | status_hit | irq_en_hit;

    err   = access & ((paddr_i[1:0] != 2'b00) | ~mapped | (pwrite_i & (|stat_hit)));
    // A CTRL write waits until the previous push on that channel is accepted.
    stall = access & pwrite_i & ~err & (|(ctrl_hit & pend));
    done  = access & ~stall & ~err;
    wr    = done & pwrite_i;
    rd    = done & ~pwrite_i;

    clr_new = (wr & status_hit) ? pwdata_i[4 +: NUM_CH] : '0;
    clr_ovf = (wr & status_hit) ? pwdata_i[8 +: NUM_CH] : '0;

    rdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ctrl_hit[i]) rdata = ctrl[i];
      if (stat_hit[i]) rdata = stat[i];
    end
    if (status_hit) rdata = 32'(pend) | (32'(new_flag) << 4) | (32'(ovf_flag) << 8);
    if (irq_en_hit) rdata = 32'(irq_en);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl     <= '0;
      stat     <= '0;
      pend     <= '0;
      new_flag <= '0;
      ovf_flag <= '0;
      irq_en   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr && ctrl_hit[i]) begin
          ctrl[i] <= pwdata_i;
          pend[i] <= 1'b1;
        end else if (pend[i] && reg2ip_ack_i[i]) begin
          pend[i] <= 1'b0;
        end
        if (ip2reg_valid_i[i]) stat[i] <= ip2reg_data_i[i];
      end
      // A W1C of new on the same edge as a fresh update counts as consumed first,
      // so that update sets new again but is not an overflow.
      new_flag <= (new_flag & ~clr_new) | ip2reg_valid_i;
      ovf_flag <= (ovf_flag & ~clr_ovf) | (ip2reg_valid_i & new_flag & ~clr_new);
      if (wr && irq_en_hit) irq_en <= pwdata_i[NUM_CH-1:0];
    end
  end

  assign pready_o       = ~stall;
  assign pslverr_o      = err & rst_ni;
  assign prdata_o       = (rd & rst_ni) ? rdata : '0;
  assign reg2ip_data_o  = ctrl;
  assign reg2ip_valid_o = pend;
  assign irq_o          = |((new_flag | ovf_flag) & irq_en);

endmodule

// File: tb/tb_custom_ip_regfile.sv
// Self-checking bench for custom_ip_regfile: directed scenarios plus randomized
// traffic compared against a register-level model of the map.
module tb_custom_ip_regfile;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             psel = 1'b0;
  logic             penable = 1'b0;
  logic             pwrite = 1'b0;
  logic [11:0]      paddr = '0;
  logic [31:0]      pwdata = '0;
  logic [31:0]      prdata;
  logic             pready;
  logic             pslverr;
  logic [2:0][31:0] r2i_data;
  logic [2:0]       r2i_valid;
  logic [2:0]       ack = '0;
  logic [2:0][31:0] i2r_data = '0;
  logic [2:0]       i2r_valid = '0;
  logic             irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ctrl [3];
  logic [31:0] m_stat [3];
  logic [2:0]  m_pend, m_new, m_ovf, m_irqen;

  always #5 clk = ~clk;

  custom_ip_regfile #(.NUM_CH(3)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .psel_i         (psel),
    .penable_i      (penable),
    .pwrite_i       (pwrite),
    .paddr_i        (paddr),
    .pwdata_i       (pwdata),
    .prdata_o       (prdata),
    .pready_o       (pready),
    .pslverr_o      (pslverr),
    .reg2ip_data_o  (r2i_data),
    .reg2ip_valid_o (r2i_valid),
    .reg2ip_ack_i   (ack),
    .ip2reg_data_i  (i2r_data),
    .ip2reg_valid_i (i2r_valid),
    .irq_o          (irq)
  );

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ctrl[i] = '0;
      m_stat[i] = '0;
    end
    m_pend = '0; m_new = '0; m_ovf = '0; m_irqen = '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h000: return m_ctrl[0];
      12'h004: return m_ctrl[1];
      12'h008: return m_ctrl[2];
      12'h00C: return m_stat[0];
      12'h010: return m_stat[1];
      12'h014: return m_stat[2];
      12'h018: return {21'd0, m_ovf, 1'b0, m_new, 1'b0, m_pend};
      12'h01C: return {29'd0, m_irqen};
      default: return '0;
    endcase
  endfunction

  function automatic logic model_irq();
    return |((m_new | m_ovf) & m_irqen);
  endfunction

  task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                          output logic [31:0] rdat, output logic serr);
    logic got = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (pready) begin got = 1'b1; break; end
    end
    rdat = prdata;
    serr = pslverr;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL apb_timeout addr=%h: pready=0 after 50 cycles, required 1", a);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic ip_pulse(input logic [2:0] mask, input logic [2:0][31:0] d);
    @(posedge clk); #1;
    i2r_valid = mask; i2r_data = d;
    @(posedge clk); #1;
    i2r_valid = '0;
    for (int i = 0; i < 3; i++)
      if (mask[i]) begin
        m_ovf[i] = m_ovf[i] | m_new[i];
        m_new[i] = 1'b1;
        m_stat[i] = d[i];
      end
  endtask

  task automatic read_all(input string tag);
    logic [31:0] rdat; logic serr;
    for (int k = 0; k < 8; k++) begin
      apb_xfer(1'b0, 12'(4 * k), '0, rdat, serr);
      checks++;
      if (rdat !== model_read(12'(4 * k)) || serr !== 1'b0) begin
        errors++;
        $display("FAIL %s_read[%h]: got %h err=%b, required %h err=0", tag, 4 * k, rdat, serr,
                 model_read(12'(4 * k)));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 12'h020;
    repeat (2) @(negedge clk);
    checks++; if (r2i_valid !== 3'b0) begin errors++; $display("FAIL rst_valid: got %b, required 000", r2i_valid); end
    checks++; if (r2i_data !== '0) begin errors++; $display("FAIL rst_data: got %h, required 0", r2i_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b, required 0", irq); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL rst_prdata: got %h, required 0", prdata); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b, required 0", pslverr); end
    psel = 1'b0; penable = 1'b0; paddr = '0;
    rst_n = 1'b1;
    model_reset();
    read_all("reset");
  endtask

  task automatic test_ctrl_push();
    logic [31:0] rdat; logic serr; int vcnt = 0;
    apb_xfer(1'b1, 12'h004, 32'hDEADBEEF, rdat, serr);
    m_ctrl[1] = 32'hDEADBEEF; m_pend[1] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (r2i_valid[1]) vcnt++;
      if (n == 1) begin
        checks++;
        if (r2i_data[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL push_data: got %h, required deadbeef", r2i_data[1]); end
      end
      ack[1] = (n == 3);
    end
    m_pend[1] = 1'b0;
    checks++; if (vcnt != 3) begin errors++; $display("FAIL push_valid_cycles: got %0d, required 3", vcnt); end
    apb_xfer(1'b0, 12'h018, '0, rdat, serr);
    checks++; if (rdat[1] !== 1'b0) begin errors++; $display("FAIL push_status_pend: got %b, required 0", rdat[1]); end
    apb_xfer(1'b0, 12'h004, '0, rdat, serr);
    checks++; if (rdat !== 32'hDEADBEEF) begin errors++; $display("FAIL push_ctrl1_read: got %h, required deadbeef", rdat); end
  endtask

  task automatic test_stall();
    logic [31:0] rdat; logic serr; int stalls = 0; logic fin = 1'b0;
    apb_xfer(1'b1, 12'h004, 32'h1111, rdat, serr);
    m_ctrl[1] = 32'h1111; m_pend[1] = 1'b1;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h1234;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int n = 1; n <= 20 && !fin; n++) begin
      @(negedge clk);
      if (pready) fin = 1'b1;
      else begin
        stalls++;
        checks++;
        if (r2i_data[1] !== 32'h1111) begin errors++; $display("FAIL stall_data_stable: got %h, required 1111", r2i_data[1]); end
      end
      ack[1] = (n == 5);
      @(posedge clk); #1;
    end
    ack = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    checks++; if (!fin || stalls != 5) begin errors++; $display("FAIL stall_cycles: got %0d done=%b, required 5 done=1", stalls, fin); end
    @(negedge clk);
    checks++;
    if (r2i_valid[1] !== 1'b1 || r2i_data[1] !== 32'h1234) begin
      errors++; $display("FAIL stall_push: got valid=%b data=%h, required valid=1 data=1234", r2i_valid[1], r2i_data[1]);
    end
    ack[1] = 1'b1;
    @(negedge clk);
    ack = '0;
    m_ctrl[1] = 32'h1234; m_pend[1] = 1'b0;
    apb_xfer(1'b0, 12'h004, '0, rdat, serr);
    checks++; if (rdat !== 32'h1234) begin errors++; $display("FAIL stall_ctrl1_read: got %h, required 1234", rdat); end
  endtask

  task automatic test_status_ovf();
    logic [31:0] rdat; logic serr; logic [2:0][31:0] d = '0;
    apb_xfer(1'b1, 12'h01C, 32'h4, rdat, serr);
    m_irqen = 3'b100;
    d[2] = 32'h48D0; ip_pulse(3'b100, d);
    d[2] = 32'h48D1; ip_pulse(3'b100, d);
    apb_xfer(1'b0, 12'h014, '0, rdat, serr);
    checks++; if (rdat !== 32'h48D1) begin errors++; $display("FAIL ovf_stat2: got %h, required 48d1", rdat); end
    apb_xfer(1'b0, 12'h018, '0, rdat, serr);
    checks++; if (rdat !== 32'h440) begin errors++; $display("FAIL ovf_status: got %h, required 00000440", rdat); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq: got %b, required 1", irq); end
    // W1C of new/ovf on the same edge as another channel-2 update
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h018; pwdata = 32'h440;
    @(posedge clk); #1;
    penable = 1'b1; i2r_valid = 3'b100; i2r_data[2] = 32'h48D2;
    @(negedge clk);
    checks++; if (pready !== 1'b1) begin errors++; $display("FAIL w1c_pready: got %b, required 1", pready); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; i2r_valid = '0;
    m_new[2] = 1'b1; m_ovf[2] = 1'b0; m_stat[2] = 32'h48D2;
    apb_xfer(1'b0, 12'h018, '0, rdat, serr);
    checks++; if (rdat !== 32'h040) begin errors++; $display("FAIL w1c_collide_status: got %h, required 00000040", rdat); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_collide_irq: got %b, required 1", irq); end
    apb_xfer(1'b1, 12'h018, 32'h040, rdat, serr);
    m_new[2] = 1'b0;
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_clear_irq: got %b, required 0", irq); end
  endtask

  task automatic test_errors();
    logic [31:0] rdat; logic serr;
    logic [11:0] ea [5] = '{12'h020, 12'h002, 12'h00C, 12'h001, 12'h024};
    logic        ew [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      apb_xfer(ew[k], ea[k], 32'hFFFF_FFFF, rdat, serr);
      checks++;
      if (serr !== 1'b1 || rdat !== 32'h0) begin
        errors++; $display("FAIL err_access[%h]: got err=%b rdata=%h, required err=1 rdata=0", ea[k], serr, rdat);
      end
    end
    @(negedge clk);
    checks++; if (r2i_valid !== m_pend) begin errors++; $display("FAIL err_no_push: got %b, required %b", r2i_valid, m_pend); end
    read_all("err");
  endtask

  task automatic test_random();
    logic [31:0] rdat; logic serr; logic [31:0] d; logic [2:0][31:0] pd; int ch; int op;
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 5));
      ch = int'($urandom_range(0, 2));
      d = $urandom;
      case (op)
        0: if (!m_pend[ch]) begin
             apb_xfer(1'b1, 12'(4 * ch), d, rdat, serr);
             m_ctrl[ch] = d; m_pend[ch] = 1'b1;
           end
        1: begin
             @(negedge clk); ack = 3'(d);
             @(negedge clk); ack = '0;
             m_pend = m_pend & ~3'(d);
           end
        2: begin
             for (int i = 0; i < 3; i++) pd[i] = $urandom;
             ip_pulse(3'(d), pd);
           end
        3: begin
             apb_xfer(1'b1, 12'h018, d, rdat, serr);
             m_new = m_new & ~d[6:4];
             m_ovf = m_ovf & ~d[10:8];
           end
        4: begin
             apb_xfer(1'b1, 12'h01C, d, rdat, serr);
             m_irqen = d[2:0];
           end
        default: begin
             apb_xfer(1'b0, 12'(4 * ch + 4 * int'(d[1:0])), '0, rdat, serr);
             checks++;
             if (rdat !== model_read(12'(4 * ch + 4 * int'(d[1:0])))) begin
               errors++; $display("FAIL rand_read[%h]: got %h, required %h", 4 * ch + 4 * int'(d[1:0]),
                                  rdat, model_read(12'(4 * ch + 4 * int'(d[1:0]))));
             end
           end
      endcase
      @(negedge clk);
      checks++;
      if (r2i_valid !== m_pend || irq !== model_irq()) begin
        errors++; $display("FAIL rand_state it=%0d: got valid=%b irq=%b, required valid=%b irq=%b",
                           it, r2i_valid, irq, m_pend, model_irq());
      end
      checks++;
      if (r2i_data[0] !== m_ctrl[0] || r2i_data[1] !== m_ctrl[1] || r2i_data[2] !== m_ctrl[2]) begin
        errors++; $display("FAIL rand_push_data it=%0d: got %h, required %h %h %h", it, r2i_data,
                           m_ctrl[2], m_ctrl[1], m_ctrl[0]);
      end
    end
    read_all("rand");
  endtask

  task automatic test_reset_stall();
    logic [31:0] rdat; logic serr; logic [2:0][31:0] d = '0;
    @(negedge clk); ack = 3'b111;
    @(negedge clk); ack = '0;
    m_pend = '0;
    apb_xfer(1'b1, 12'h01C, 32'h7, rdat, serr);
    m_irqen = 3'b111;
    d[0] = 32'hCAFE;
    ip_pulse(3'b001, d);
    apb_xfer(1'b1, 12'h000, 32'hA5A5, rdat, serr);
    m_ctrl[0] = 32'hA5A5; m_pend[0] = 1'b1;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    checks++; if (pready !== 1'b0 || irq !== 1'b1) begin errors++; $display("FAIL rs_pre: got pready=%b irq=%b, required 0 1", pready, irq); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (r2i_valid !== 3'b0 || r2i_data !== '0) begin errors++; $display("FAIL rs_push_out: got valid=%b data=%h, required 0", r2i_valid, r2i_data); end
    checks++; if (irq !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0) begin
      errors++; $display("FAIL rs_apb_out: got irq=%b prdata=%h pslverr=%b, required 0", irq, prdata, pslverr);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apb_xfer(1'b0, 12'h000, '0, rdat, serr);
    checks++; if (rdat !== 32'h0) begin errors++; $display("FAIL rs_ctrl0: got %h, required 0", rdat); end
    @(negedge clk);
    checks++; if (r2i_valid !== 3'b0) begin errors++; $display("FAIL rs_valid: got %b, required 000", r2i_valid); end
    read_all("rs");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ctrl_push();
    test_stall();
    test_status_ovf();
    test_errors();
    test_random();
    test_reset_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at 500000, required completion");
    $fatal(1, "timeout");
  end

endmodule
